// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one requester's access port into mem_arbiter.
// The requester uses the master modport, the arbiter the slave modport.
interface mem_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          lock;
  logic          gnt;
  logic [DW-1:0] rdata;
  logic          rvalid;

  modport master (output req, we, addr, wdata, lock, input gnt, rdata, rvalid);
  modport slave  (input req, we, addr, wdata, lock, output gnt, rdata, rvalid);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a 2**AW x DW
// single-port store. One access per clock; read data returns one cycle
// after the grant on the port that issued the read.
// Optional feature: define MEM_ARB_LOCK_EN to let a requester hold the
// grant for up to MAX_HOLD consecutive accesses via its lock input.
module mem_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          clr,
  mem_arbiter_if.slave  p0,
  mem_arbiter_if.slave  p1
);

  localparam logic PRI0 = 1'b0;
  localparam logic PRI1 = 1'b1;

  logic [1:0]    req;
  logic [1:0]    base_gnt;
  logic [1:0]    gnt;
  logic          ptr_q, ptr_d;
  logic          acc_fire;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_owner_q, rd_owner_d;
  logic [DW-1:0] mem_rdata_q;
  logic [DW-1:0] mem [2**AW];
  logic [1:0]    rvalid;
  logic [DW-1:0] rdata_o [2];

  assign req = {p1.req, p0.req};

  // Plain round-robin pick; nothing is granted while reset is asserted.
  always_comb begin
    base_gnt = 2'b00;
    if (clr) begin
      if (req == 2'b11) base_gnt = (ptr_q == PRI1) ? 2'b10 : 2'b01;
      else              base_gnt = req;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  localparam logic [1:0] ARB   = 2'd0;
  localparam logic [1:0] HOLD0 = 2'd1;
  localparam logic [1:0] HOLD1 = 2'd2;
  localparam int         CW    = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_HOLD);

  logic [1:0]    lock;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign lock = {p1.lock, p0.lock};

  // Hold FSM: a locked owner keeps the grant until it lets go or the
  // counter saturates; on exit, the same cycle falls back to round-robin.
  always_comb begin
    gnt     = base_gnt;
    state_d = ARB;
    cnt_d   = '0;
    if (clr && state_q == HOLD0 && req[0] && lock[0] && cnt_q < MAX_CNT) begin
      gnt     = 2'b01;
      state_d = HOLD0;
      cnt_d   = cnt_q + CW'(1);
    end else if (clr && state_q == HOLD1 && req[1] && lock[1] && cnt_q < MAX_CNT) begin
      gnt     = 2'b10;
      state_d = HOLD1;
      cnt_d   = cnt_q + CW'(1);
    end else if (base_gnt[0] && lock[0]) begin
      state_d = HOLD0;
      cnt_d   = CW'(1);
    end else if (base_gnt[1] && lock[1]) begin
      state_d = HOLD1;
      cnt_d   = CW'(1);
    end
  end

  // Hold FSM state and consecutive-grant counter.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ARB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^{p0.lock, p1.lock, MAX_HOLD != 0};
  assign gnt = base_gnt;
`endif

  // Pointer always favours the requester that was not just served, so a
  // hold that ends on saturation hands the next contest to the other side.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0])      ptr_d = PRI1;
    else if (gnt[1]) ptr_d = PRI0;
  end

  // Steer the granted requester's command onto the single store port.
  always_comb begin
    acc_fire  = |gnt;
    acc_we    = p0.we;
    acc_addr  = p0.addr;
    acc_wdata = p0.wdata;
    if (gnt[1]) begin
      acc_we    = p1.we;
      acc_addr  = p1.addr;
      acc_wdata = p1.wdata;
    end
    rd_pend_d  = acc_fire & ~acc_we;
    rd_owner_d = acc_fire ? gnt[1] : rd_owner_q;
  end

  // Store: write or registered read, at most one per clock; not reset.
  always_ff @(posedge clk) begin
    if (acc_fire && acc_we)  mem[acc_addr] <= acc_wdata;
    if (acc_fire && !acc_we) mem_rdata_q   <= mem[acc_addr];
  end

  // Arbitration pointer and outstanding-read tracking.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ptr_q      <= PRI0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Per-port return path: pulse rvalid to the owner and keep the last
  // read value on rdata until that same port's next read lands.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [DW-1:0] hold_q, hold_d;

    assign rvalid[gi]  = rd_pend_q & (rd_owner_q == 1'(gi));
    assign hold_d      = rvalid[gi] ? mem_rdata_q : hold_q;
    assign rdata_o[gi] = rvalid[gi] ? mem_rdata_q : hold_q;

    // Last delivered read data for this port.
    always_ff @(posedge clk or negedge clr) begin
      if (!clr) hold_q <= '0;
      else      hold_q <= hold_d;
    end
  end

  assign p0.gnt    = gnt[0];
  assign p1.gnt    = gnt[1];
  assign p0.rvalid = rvalid[0];
  assign p1.rvalid = rvalid[1];
  assign p0.rdata  = rdata_o[0];
  assign p1.rdata  = rdata_o[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. Reads are pushed
// to a scoreboard when granted and popped when rvalid returns.
module tb_mem_arbiter;

  typedef struct {
    logic       owner;
    logic [7:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] mem_m [32];
  logic [7:0] exp_rdata [2];
  rd_t        sb_q [$];

  mem_arbiter_if #(.AW(5), .DW(8)) if0 ();
  mem_arbiter_if #(.AW(5), .DW(8)) if1 ();

  mem_arbiter #(.AW(5), .DW(8), .MAX_HOLD(4)) dut (
    .clk (clk),
    .clr (clr),
    .p0  (if0),
    .p1  (if1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus, entered and left at posedge+2.
  task automatic drive(input logic r0, input logic w0, input logic [4:0] a0,
                       input logic [7:0] d0, input logic l0,
                       input logic r1, input logic w1, input logic [4:0] a1,
                       input logic [7:0] d1, input logic l1,
                       input logic [1:0] exp_gnt);
    rd_t  pend;
    logic have;
    if0.req = r0; if0.we = w0; if0.addr = a0; if0.wdata = d0; if0.lock = l0;
    if1.req = r1; if1.we = w1; if1.addr = a1; if1.wdata = d1; if1.lock = l1;
    #1;
    check("gnt", 32'({if1.gnt, if0.gnt}), 32'(exp_gnt));
    have = 1'b0;
    pend.owner = 1'b0;
    pend.data  = 8'h00;
    if (exp_gnt[0]) begin
      if (w0) mem_m[a0] = d0;
      else begin pend.owner = 1'b0; pend.data = mem_m[a0]; have = 1'b1; end
    end else if (exp_gnt[1]) begin
      if (w1) mem_m[a1] = d1;
      else begin pend.owner = 1'b1; pend.data = mem_m[a1]; have = 1'b1; end
    end
    $display("txn t=%0t req=%b%b we=%b%b gnt=%b%b", $time, r1, r0, w1, w0, if1.gnt, if0.gnt);
    @(posedge clk);
    #2;
    if (have) sb_q.push_back(pend);
  endtask

  task automatic idle();
    drive(0, 0, 5'd0, 8'h00, 0, 0, 0, 5'd0, 8'h00, 0, 2'b00);
  endtask

  // Read-return monitor: rvalid must match the scoreboard head each cycle
  // and rdata must equal the last value delivered to that port.
  always @(negedge clk) begin : mon
    logic ev0, ev1;
    rd_t  e;
    if (clr) begin
      ev0 = (sb_q.size() > 0) && (sb_q[0].owner == 1'b0);
      ev1 = (sb_q.size() > 0) && (sb_q[0].owner == 1'b1);
      check("rvalid0", 32'(if0.rvalid), 32'(ev0));
      check("rvalid1", 32'(if1.rvalid), 32'(ev1));
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        exp_rdata[e.owner] = e.data;
      end
      check("rdata0", 32'(if0.rdata), 32'(exp_rdata[0]));
      check("rdata1", 32'(if1.rdata), 32'(exp_rdata[1]));
    end
  end

  initial begin
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    // Reset held with both requesting.
    clr = 1'b0;
    if0.req = 1; if0.we = 0; if0.addr = 5'd0; if0.wdata = 8'h00; if0.lock = 0;
    if1.req = 1; if1.we = 0; if1.addr = 5'd0; if1.wdata = 8'h00; if1.lock = 0;
    #1;
    check("rst_gnt0", 32'(if0.gnt), 32'd0);
    check("rst_gnt1", 32'(if1.gnt), 32'd0);
    check("rst_rvalid0", 32'(if0.rvalid), 32'd0);
    check("rst_rvalid1", 32'(if1.rvalid), 32'd0);
    check("rst_rdata0", 32'(if0.rdata), 32'd0);
    check("rst_rdata1", 32'(if1.rdata), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    clr = 1'b1;

    // First contest goes to requester 0; preload addrs 1 and 2.
    drive(1, 1, 5'd1, 8'h11, 0, 1, 1, 5'd2, 8'h22, 0, 2'b01);
    drive(0, 0, 5'd0, 8'h00, 0, 1, 1, 5'd2, 8'h22, 0, 2'b10);

    // Single requester write then read of addr 3.
    drive(1, 1, 5'd3, 8'hA5, 0, 0, 0, 5'd0, 8'h00, 0, 2'b01);
    drive(1, 0, 5'd3, 8'h00, 0, 0, 0, 5'd0, 8'h00, 0, 2'b01);
    // Requester 1 alone, leaving the pointer on requester 0.
    drive(0, 0, 5'd0, 8'h00, 0, 1, 0, 5'd2, 8'h00, 0, 2'b10);

    // Continuous contention: strict alternation of grants and read returns.
    for (int i = 0; i < 6; i++)
      drive(1, 0, 5'd1, 8'h00, 0, 1, 0, 5'd2, 8'h00, 0, (i % 2 == 0) ? 2'b01 : 2'b10);

    // Cross read-after-write at the top address.
    drive(0, 0, 5'd0, 8'h00, 0, 1, 1, 5'd31, 8'h3C, 0, 2'b10);
    drive(1, 0, 5'd31, 8'h00, 0, 0, 0, 5'd0, 8'h00, 0, 2'b01);
    idle();

    // Reset right after a read grant: the read is discarded.
    drive(1, 0, 5'd3, 8'h00, 0, 0, 0, 5'd0, 8'h00, 0, 2'b01);
    clr = 1'b0;
    sb_q.delete();
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    #1;
    check("midrst_rvalid0", 32'(if0.rvalid), 32'd0);
    check("midrst_rdata0", 32'(if0.rdata), 32'd0);
    @(posedge clk);
    #2;
    check("midrst_rvalid0_hold", 32'(if0.rvalid), 32'd0);
    clr = 1'b1;
    idle();
    drive(1, 1, 5'd4, 8'h44, 0, 1, 1, 5'd5, 8'h55, 0, 2'b01);
    drive(0, 0, 5'd0, 8'h00, 0, 1, 1, 5'd5, 8'h55, 0, 2'b10);

    // Locked requester 0 against requester 1.
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_LOCK_EN
      drive(1, 1, 5'd6, 8'h66, 1, 1, 0, 5'd1, 8'h00, 0, (i == 4) ? 2'b10 : 2'b01);
`else
      drive(1, 1, 5'd6, 8'h66, 1, 1, 0, 5'd1, 8'h00, 0, (i % 2 == 0) ? 2'b01 : 2'b10);
`endif
    end
    idle();
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port round-robin arbiter in front of a 32x8 single-port store. The store uses a registered read address and has a 1-cycle read latency.
- Lets two requesters, for example a traffic generator and a writeback unit, share one memory.
- Exactly one access (read or write) is performed per clock, and read data is steered back to the requester that issued the read.

Parameters:
- AW, 5, address width; depth = 2**AW.
- DW, 8, data width.
- MAX_HOLD, 4, maximum consecutive locked grants (used only with MEM_ARB_LOCK_EN).

Ports:
- clk  in  1  clock; all state updates on posedge.
- clr  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 access request.
- we0  in  1  requester 0: 1 = write, 0 = read.
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- lock0  in  1  requester 0 hold-grant request; ignored without MEM_ARB_LOCK_EN.
- gnt0  out  1  requester 0 grant (combinational); access occurs on this edge.
- rdata0  out  DW  requester 0 read data.
- rvalid0  out  1  requester 0 read data valid, 1-cycle pulse.
- req1, we1, addr1, wdata1, lock1, gnt1, rdata1, rvalid1: same as above, for requester 1.

Behaviour:
- Reset (clr=0, asynchronous):
  - gnt0, gnt1, rvalid0, rvalid1 = 0.
  - rdata0, rdata1 = 0.
  - Priority pointer = 0, so requester 0 wins first.
  - Hold counter = 0; read-owner register cleared.
  - Array contents are not reset.
- Handshake:
  - A requester asserts reqN with weN/addrN/wdataN stable and holds them until a cycle with gntN=1.
  - A transfer completes on the posedge where reqN & gntN.
  - Dropping reqN before a grant is legal; nothing is performed.
- Grant logic (combinational):
  - At most one of gnt0/gnt1 is high; gntN never asserts without reqN.
  - Only one requester asserting: it is granted.
  - Both asserting: the requester indicated by the priority pointer is granted.
  - After each grant, the pointer moves to the other requester, giving strict alternation under continuous contention.
  - No requests: pointer unchanged.
- Write: mem[addrN] <= wdataN at the granting edge; no rvalid is generated.
- Read:
  - At the granting edge, addrN and the owner id are registered.
  - In the following cycle, rvalidN=1 and rdataN = mem[registered addr].
  - rdataN holds its value until that requester's next read completes; the other requester's rdata is unaffected.
- Read throughput: back-to-back reads by the same or alternating requesters give one rvalid per cycle, each pulse on the correct owner.
- Read-after-write: a write to address A at edge k followed by a read of A granted at edge k+1 returns the new data.
- Address wrap: the address is exactly AW bits; no out-of-range case exists.
- Reset mid-operation: a read granted on the edge before clr falls is discarded; rvalid stays 0 after release until a new read completes.
- Internal state: 2-state pointer (PRI0, PRI1), plus a hold-counter FSM when the optional feature is enabled.

Optional Feature:
- Macro MEM_ARB_LOCK_EN.
- Defined: FSM with states ARB, HOLD0, HOLD1.
  - A grant to N with lockN=1 in state ARB moves the FSM to HOLDN with the counter set to 1.
  - In HOLDN, requester N is granted exclusively while reqN & lockN, and the counter increments per grant.
  - Return to ARB when lockN=0, reqN=0, or the counter reaches MAX_HOLD.
  - On a forced return (counter reached MAX_HOLD), the pointer favours the other requester for the next arbitration.
  - The other requester's gnt stays 0 throughout HOLDN.
- Undefined: lock0/lock1 are ignored, no hold FSM is built, and behaviour is plain round-robin.

Test Plan:
- Reset values: hold clr=0 with req0=req1=1 -> gnt0=gnt1=0, rvalid*=0, rdata*=0; release clr -> first grant goes to requester 0.
- Single requester: req0 writes 8'hA5 to addr 5'd3, then reads addr 3 -> gnt0 each cycle; rvalid0=1 with rdata0=8'hA5 one cycle after the read grant; rvalid1 stays 0.
- Contention: req0 and req1 held high for 6 cycles, reading addrs 1 and 2 (preloaded 8'h11, 8'h22) -> grants alternate 0,1,0,1,0,1; rvalid0/rvalid1 alternate with 8'h11 / 8'h22.
- Cross read-after-write: req1 writes 8'h3C to addr 31, then req0 reads addr 31 on the next edge -> rdata0=8'h3C, rdata1 unchanged.
- Reset during a read: read granted at edge k, clr pulsed low before edge k+1 -> rvalid0 stays 0 and the next grant goes to requester 0.
- MEM_ARB_LOCK_EN, MAX_HOLD=4: req0/lock0 held high with req1=1 -> gnt0 for 4 consecutive cycles, then gnt1 for 1 cycle; without the macro -> strict alternation.
